// File: rtl/fork_waiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fork_waiter_if
// Purpose  : Request/grant bundle between a philosopher ring and fork_waiter.
// Revision : 1.0  initial release
// ============================================================================
interface fork_waiter_if #(
    parameter int N = 5
) ();
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [N-1:0] fork_busy;
    logic [N-1:0] starving;

    modport master (output req, done, input grant, fork_busy, starving);
    modport slave  (input req, done, output grant, fork_busy, starving);
endinterface
`default_nettype wire

// File: rtl/fork_waiter.sv
`default_nettype none
// ============================================================================
// Module   : fork_waiter
// Purpose  : Round-robin waiter for N dining philosophers with bounded eating;
//            optional starvation aging enabled by defining WAITER_AGING_EN.
// Revision : 1.0  initial release
// ============================================================================
module fork_waiter #(
    parameter int N         = 5,
    parameter int EAT_MAX   = 4,
    parameter int AGE_LIMIT = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    fork_waiter_if.slave bus
);
    localparam int RW = $clog2(N);
    localparam int EW = $clog2(EAT_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        EAT  = 1'b1
    } state_t;

    state_t          r_state [N];
    logic [EW-1:0]   r_ec    [N];
    logic [RW-1:0]   r_rr;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    r_fork_busy;

    logic [N-1:0]    w_idle;
    logic [N-1:0]    w_release;
    logic [N-1:0]    w_new;
    logic [N-1:0]    w_taken;
    logic [N-1:0]    w_grant_nxt;
    logic [RW-1:0]   w_last;
    logic [RW-1:0]   w_idx;
    logic [RW-1:0]   w_nxt;
    logic            w_any;

    if (N < 3 || EAT_MAX < 1 || AGE_LIMIT < 1) begin : g_bad_config
        $error("fork_waiter: unsupported parameter set");
    end

    for (genvar i = 0; i < N; i++) begin : g_phil
        assign w_idle[i]    = (r_state[i] == IDLE);
        assign w_release[i] = (r_state[i] == EAT) &&
                              (bus.done[i] || (r_ec[i] == EW'(EAT_MAX)));
    end

`ifdef WAITER_AGING_EN
    localparam int WW = $clog2(AGE_LIMIT + 1);

    logic [N-1:0][WW-1:0] r_wc;
    logic [N-1:0][WW-1:0] w_wc_nxt;
    logic [N-1:0]         r_starving;
    logic [N-1:0]         w_reserve;
    logic [RW-1:0]        w_prv;

    for (genvar i = 0; i < N; i++) begin : g_age
        assign w_wc_nxt[i] = (w_new[i] || !bus.req[i])                   ? '0 :
                             (w_idle[i] && r_wc[i] != WW'(AGE_LIMIT)) ? r_wc[i] + WW'(1) :
                                                                          r_wc[i];
    end
    assign bus.starving = r_starving;
`else
    assign bus.starving = '0;
`endif

    // Forks held at the start of the cycle stay taken even if released now,
    // so a released fork can only be re-granted one edge later.
    always_comb begin
        w_taken = r_fork_busy;
        w_new   = '0;
        w_any   = 1'b0;
        w_last  = r_rr;
        w_idx   = '0;
        w_nxt   = '0;
`ifdef WAITER_AGING_EN
        w_prv     = '0;
        w_reserve = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = RW'((int'(r_rr) + k) % N);
            w_nxt = RW'((int'(w_idx) + 1) % N);
            if (bus.req[w_idx] && w_idle[w_idx] && r_starving[w_idx] &&
                !w_taken[w_idx] && !w_taken[w_nxt]) begin
                w_new[w_idx]   = 1'b1;
                w_taken[w_idx] = 1'b1;
                w_taken[w_nxt] = 1'b1;
                w_any          = 1'b1;
                w_last         = w_idx;
            end
        end
        // Starving requesters left waiting keep both their forks reserved.
        w_reserve = bus.req & w_idle & r_starving & ~w_new;
        for (int k = 0; k < N; k++) begin
            w_idx = RW'((int'(r_rr) + k) % N);
            w_nxt = RW'((int'(w_idx) + 1) % N);
            w_prv = RW'((int'(w_idx) + N - 1) % N);
            if (bus.req[w_idx] && w_idle[w_idx] && !r_starving[w_idx] &&
                !w_reserve[w_prv] && !w_reserve[w_nxt] &&
                !w_taken[w_idx] && !w_taken[w_nxt]) begin
                w_new[w_idx]   = 1'b1;
                w_taken[w_idx] = 1'b1;
                w_taken[w_nxt] = 1'b1;
                w_any          = 1'b1;
                w_last         = w_idx;
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            w_idx = RW'((int'(r_rr) + k) % N);
            w_nxt = RW'((int'(w_idx) + 1) % N);
            if (bus.req[w_idx] && w_idle[w_idx] &&
                !w_taken[w_idx] && !w_taken[w_nxt]) begin
                w_new[w_idx]   = 1'b1;
                w_taken[w_idx] = 1'b1;
                w_taken[w_nxt] = 1'b1;
                w_any          = 1'b1;
                w_last         = w_idx;
            end
        end
`endif
    end

    assign w_grant_nxt = (~w_idle & ~w_release) | w_new;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= IDLE;
                r_ec[i]    <= '0;
            end
            r_rr        <= '0;
            r_grant     <= '0;
            r_fork_busy <= '0;
`ifdef WAITER_AGING_EN
            r_wc        <= '0;
            r_starving  <= '0;
`endif
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_state[i] == IDLE) begin
                    if (w_new[i]) begin
                        r_state[i] <= EAT;
                        r_ec[i]    <= EW'(1);
                    end
                end else if (w_release[i]) begin
                    r_state[i] <= IDLE;
                    r_ec[i]    <= '0;
                end else begin
                    r_ec[i] <= r_ec[i] + EW'(1);
                end
            end
            if (w_any) begin
                r_rr <= RW'((int'(w_last) + 1) % N);
            end
            r_grant     <= w_grant_nxt;
            r_fork_busy <= w_grant_nxt | {w_grant_nxt[N-2:0], w_grant_nxt[N-1]};
`ifdef WAITER_AGING_EN
            r_wc <= w_wc_nxt;
            for (int i = 0; i < N; i++) begin
                r_starving[i] <= (w_wc_nxt[i] == WW'(AGE_LIMIT));
            end
`endif
        end
    end

    assign bus.grant     = r_grant;
    assign bus.fork_busy = r_fork_busy;

endmodule
`default_nettype wire

// File: tb/tb_fork_waiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fork_waiter
// Purpose  : Scoreboard bench for fork_waiter (N=5, EAT_MAX=4, AGE_LIMIT=12).
// Revision : 1.0  initial release
// ============================================================================
module tb_fork_waiter;
    localparam int N       = 5;
    localparam int EAT_MAX = 4;
    localparam logic [1:0] K_EXACT = 2'd0;
    localparam logic [1:0] K_CONT  = 2'd1;

    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] g;
        logic [4:0] b;
        logic [4:0] s;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    fork_waiter_if #(.N(N)) bus ();

    fork_waiter #(.N(N), .EAT_MAX(EAT_MAX), .AGE_LIMIT(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] busy_of(input logic [4:0] g);
        return g | {g[3:0], g[4]};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req_v);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] dn,
                        input logic [1:0] k, input logic [4:0] eg, input logic [4:0] es);
        exp_t e;
        rst_n    = r;
        bus.req  = rq;
        bus.done = dn;
        @(posedge clk);
        #1;
        e.kind = k;
        e.g    = eg;
        e.b    = busy_of(eg);
        e.s    = es;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per sampled cycle, plus invariant checks.
    exp_t       mon_e;
    logic [4:0] g;
    logic [4:0] prev_g = '0;
    int         run   [N];
    int         rel_t [N];
    logic [N-1:0] rel_v = '0;
    int         max_run;

    initial begin
        for (int i = 0; i < N; i++) begin
            run[i]   = 0;
            rel_t[i] = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            g     = bus.grant;
            if (mon_e.kind == K_EXACT) begin
                check("grant", g, mon_e.g);
                check("fork_busy", bus.fork_busy, mon_e.b);
                check("starving", bus.starving, mon_e.s);
            end
            check("no_adjacent_grants", g & {g[0], g[4:1]}, 5'b00000);
            total++;
            if ($countones(g) > N / 2) begin
                bad++;
                $display("FAIL grant_count cycle=%0d actual=%0d required<=%0d", cyc, $countones(g), N / 2);
            end
            max_run = 0;
            for (int i = 0; i < N; i++) begin
                run[i] = g[i] ? run[i] + 1 : 0;
                if (run[i] > max_run) max_run = run[i];
            end
            total++;
            if (max_run > EAT_MAX) begin
                bad++;
                $display("FAIL grant_width cycle=%0d actual=%0d required<=%0d", cyc, max_run, EAT_MAX);
            end
            if (mon_e.kind == K_CONT) begin
                for (int i = 0; i < N; i++) begin
                    if (!g[i] && prev_g[i]) begin
                        rel_t[i] = cyc;
                        rel_v[i] = 1'b1;
                    end else if (g[i] && !prev_g[i] && rel_v[i]) begin
                        total++;
                        if (cyc - rel_t[i] > 20) begin
                            bad++;
                            $display("FAIL regrant_gap idx=%0d actual=%0d required<=20", i, cyc - rel_t[i]);
                        end
                        rel_v[i] = 1'b0;
                    end else if (!g[i] && rel_v[i] && (cyc - rel_t[i] > 20)) begin
                        total++;
                        bad++;
                        $display("FAIL regrant_gap idx=%0d actual>%0d required<=20", i, cyc - rel_t[i]);
                        rel_v[i] = 1'b0;
                    end
                end
            end else begin
                rel_v = '0;
            end
            prev_g = g;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req  = '0;
        bus.done = '0;

        // Reset with everyone hungry, then first allocation from rr=0.
        step(1'b0, 5'b11111, 5'b00000, K_EXACT, 5'b00000, 5'b00000);
        step(1'b0, 5'b11111, 5'b00000, K_EXACT, 5'b00000, 5'b00000);
        step(1'b1, 5'b11111, 5'b00000, K_EXACT, 5'b00101, 5'b00000);
        step(1'b1, 5'b00000, 5'b00101, K_EXACT, 5'b00000, 5'b00000);

        // Single requester: four-cycle forced timeout, one idle cycle, regrant.
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'b00010, 5'b00000, K_EXACT, 5'b00010, 5'b00000);
        step(1'b1, 5'b00010, 5'b00000, K_EXACT, 5'b00000, 5'b00000);
        step(1'b1, 5'b00010, 5'b00000, K_EXACT, 5'b00010, 5'b00000);
        step(1'b1, 5'b00000, 5'b00010, K_EXACT, 5'b00000, 5'b00000);

        // Early done in first granted cycle.
        step(1'b1, 5'b01000, 5'b00000, K_EXACT, 5'b01000, 5'b00000);
        step(1'b1, 5'b00000, 5'b01000, K_EXACT, 5'b00000, 5'b00000);

        // Neighbour conflict: 0 and 1 alternate, release edge never regrants.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 5'b00011, 5'b00000, K_EXACT, 5'b00001, 5'b00000);
            step(1'b1, 5'b00011, 5'b00001, K_EXACT, 5'b00000, 5'b00000);
            step(1'b1, 5'b00011, 5'b00000, K_EXACT, 5'b00010, 5'b00000);
            step(1'b1, (i == 1) ? 5'b00000 : 5'b00011, 5'b00010, K_EXACT, 5'b00000, 5'b00000);
        end

        // Full contention: invariants and regrant gap only.
        for (int i = 0; i < 200; i++)
            step(1'b1, 5'b11111, 5'b00000, K_CONT, 5'b00000, 5'b00000);
        step(1'b1, 5'b00000, 5'b11111, K_EXACT, 5'b00000, 5'b00000);

        // Reset mid-meal, then rr must be back at 0.
        step(1'b1, 5'b00100, 5'b00000, K_EXACT, 5'b00100, 5'b00000);
        step(1'b0, 5'b00100, 5'b00000, K_EXACT, 5'b00000, 5'b00000);
        step(1'b1, 5'b11111, 5'b00000, K_EXACT, 5'b00101, 5'b00000);
        step(1'b1, 5'b00000, 5'b00101, K_EXACT, 5'b00000, 5'b00000);

`ifdef WAITER_AGING_EN
        // Philosophers 1 and 3 take turns so that 2 never sees both forks free.
        step(1'b0, 5'b00000, 5'b00000, K_EXACT, 5'b00000, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'b01110, 5'b00000, K_EXACT, 5'b01010, 5'b00000);
            step(1'b1, 5'b01110, 5'b00010, K_EXACT, 5'b01000, 5'b00000);
            step(1'b1, 5'b01110, 5'b00000, K_EXACT, 5'b01010, 5'b00000);
            step(1'b1, 5'b01110, 5'b01000, K_EXACT, 5'b00010, (i == 2) ? 5'b00100 : 5'b00000);
        end
        step(1'b1, 5'b01110, 5'b00000, K_EXACT, 5'b00010, 5'b00100);
        step(1'b1, 5'b01110, 5'b00010, K_EXACT, 5'b00000, 5'b00100);
        step(1'b1, 5'b01110, 5'b00000, K_EXACT, 5'b00100, 5'b00000);
        step(1'b1, 5'b00000, 5'b00100, K_EXACT, 5'b00000, 5'b00000);
`endif

        bus.req  = '0;
        bus.done = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fork_waiter.md
# fork_waiter

Centralised waiter for a ring of `N` philosophers sharing `N` forks. Philosopher `i` uses fork `i` (left) and fork `(i+1) mod N` (right). The block grants eating rights so that no fork is ever held twice, rotates priority round-robin, and forcibly reclaims forks after a bounded eating time. It sits beside the philosopher ring: philosopher FSMs raise a request when hungry and eat only while granted.

## Interface

**Parameters**
- `N`, default 5: number of philosophers and forks; must be at least 3.
- `EAT_MAX`, default 4: maximum cycles a grant stays high.
- `AGE_LIMIT`, default 12: wait cycles after which a requester is starving. Used only with aging enabled.

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req`, input, `N`: level request per philosopher (hungry).
- `done`, input, `N`: voluntary release. Sampled only while the matching grant is high.
- `grant`, output, `N`: registered eating permission.
- `fork_busy`, output, `N`: registered; bit `f` is 1 while fork `f` is held. Equals `grant | rotate_left(grant, 1)`, i.e. `fork_busy[f] = grant[f] | grant[(f-1) mod N]`.
- `starving`, output, `N`: registered aging flags. Constant 0 when aging is compiled out.

## Operation

**Reset** (`rst_n` = 0 at an edge)
- `grant`, `fork_busy`, `starving` = 0.
- Round-robin pointer `rr` = 0.
- Eat counters and wait counters = 0.

**Per-philosopher FSM**
- `IDLE`: grant = 0.
- `EAT`: grant = 1, eat counter `ec` counts 1..`EAT_MAX`.
- `IDLE` → `EAT`: when selected by the allocator.
- `EAT` → `IDLE`: when `done[i]` = 1, or when `ec` = `EAT_MAX`, whichever comes first.
- `req[i]` is ignored while in `EAT`. `done[i]` is ignored while in `IDLE`.

**Allocator** (combinational on registered state, result registered)
- Scan indices in order `rr, rr+1, …, rr+N-1`, all mod `N`.
- A fork is free only if no philosopher holds it at the start of the cycle (including one being released this cycle) and no earlier-scanned philosopher has been granted it this cycle.
- Grant `i` if `req[i]` = 1, `i` is `IDLE`, and forks `i` and `(i+1) mod N` are both free.
- `rr` update: if any new grant was made, `rr` becomes (last newly granted index + 1) mod `N`; otherwise `rr` is unchanged.

**Invariant**
- Never `grant[i] & grant[(i+1) mod N]`.
- At most `floor(N/2)` grants are high at once.

## Timing

- **Grant latency:** `req` high at edge `t` with both forks free → `grant` high after edge `t` (visible in cycle `t+1`). No combinational path from `req` or `done` to any output.
- **Release latency:** `done` high at edge `t` while granted → `grant` and the forks drop after edge `t`. Those forks can be re-granted at edge `t+1`, never at the same edge.
- **Grant width:**
  - `grant` is high for at most `EAT_MAX` consecutive cycles.
  - The forced release occurs at the edge where `ec` = `EAT_MAX`.
  - `done` in the first granted cycle gives a 1-cycle grant.
- **Re-request:**
  - A released philosopher with `req` still high is not eligible at its release edge.
  - It becomes eligible one edge later, subject to the same allocation rules.
- **Simultaneous requests:** requesters that conflict in the same cycle are resolved by scan order from `rr`.
- **Reset mid-operation:** all grants drop after the reset edge regardless of `done` or `ec`, and all counters clear.

## Configuration

- **`WAITER_AGING_EN` defined:**
  - Each philosopher has a saturating wait counter of width `$clog2(AGE_LIMIT+1)`. It increments while `req` = 1 and `IDLE`, and clears when granted or when `req` = 0.
  - `starving[i]` = 1 when the counter equals `AGE_LIMIT`.
  - The allocator runs two passes from `rr`:
    - First pass: grants starving requesters only.
    - Second pass: grants non-starving requesters, but skips any philosopher that neighbours a starving, ungranted requester. Those forks are reserved for the starving neighbour.
  - The `rr` update rule is unchanged.
- **`WAITER_AGING_EN` undefined:**
  - Single-pass round-robin only.
  - No wait counters; `starving` is tied to 0.

## Test plan

Use `N` = 5, `EAT_MAX` = 4, `AGE_LIMIT` = 12.

1. **Reset:** hold `rst_n` = 0 for 2 edges with `req` = `5'b11111` → `grant` = 0 and `fork_busy` = 0 throughout; after release, the first grant is `grant` = `5'b00101` (indices 0 and 2; 3 and 4 conflict).
2. **Single requester, timeout:** `req` = `5'b00010` held, `done` = 0 → `grant[1]` is high for exactly 4 cycles, low for 1 cycle, then high again; `fork_busy` = `5'b00110` while granted.
3. **Early done:** `req[3]` is granted and `done[3]` = 1 in the first granted cycle → 1-cycle grant; `fork_busy[3]` and `fork_busy[4]` clear on the next edge.
4. **Neighbour conflict and rotation:** `req` = `5'b00011` continuously with `done` pulsed each granted cycle → grants alternate 0, 1, 0, 1. `grant[0]` and `grant[1]` are never high together.
5. **Full contention:** `req` = `5'b11111` for 200 cycles → the per-cycle invariant check passes, no more than 2 grants are high at once, and every index is granted within 20 cycles of its previous release.
6. **Aging (`WAITER_AGING_EN` defined):** bias `done` so that philosopher 2 waits → `starving[2]` rises after 12 waiting cycles. From then on, 1 and 3 receive no new grants until 2 is granted. `starving[2]` clears on the grant edge.
